// File: rtl/fft_output_reorder.sv
// Output reorder buffer for the 32-point radix-2 MDC FFT.
// Ping-pong banks take bit-reversed sample pairs and emit bins 0..31 serially.
module fft_output_reorder #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_up_re,
    input  logic [WIDTH-1:0] in_up_im,
    input  logic [WIDTH-1:0] in_l_re,
    input  logic [WIDTH-1:0] in_l_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [4:0]       out_idx,
    output logic             out_last
);
    localparam int DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_st_e;

    bank_st_e         st_q [2];
    bank_st_e         st_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic [3:0]       wr_cnt_q, wr_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic [4:0]       rd_cnt_q, rd_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_re_q, out_re_d;
    logic [WIDTH-1:0] out_im_q, out_im_d;
    logic [4:0]       out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             out_bank_q, out_bank_d;

    logic [DW-1:0]    mem [2][32];

    logic             beat;
    logic             rd_avail;
    logic             load;
    logic             hs_last;
    logic [3:0]       wr_rev;
    logic [DW-1:0]    rd_word;

    assign wr_rev   = {wr_cnt_q[0], wr_cnt_q[1], wr_cnt_q[2], wr_cnt_q[3]};
    assign in_ready = (st_q[wr_bank_q] == EMPTY) || (st_q[wr_bank_q] == FILLING);
    assign beat     = in_valid && in_ready;
    assign rd_avail = (st_q[rd_bank_q] == FULL) || (st_q[rd_bank_q] == DRAINING);
    assign load     = rd_avail && (!out_valid_q || out_ready);
    assign hs_last  = out_valid_q && out_ready && out_last_q;
    assign rd_word  = mem[rd_bank_q][rd_cnt_q];

    // Storage is left unreset; bank state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_bank_q][{1'b0, wr_rev}] <= {in_up_re, in_up_im};
            mem[wr_bank_q][{1'b1, wr_rev}] <= {in_l_re, in_l_im};
        end
    end

    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_bank_d  = out_bank_q;
        for (int b = 0; b < 2; b++) begin
            st_d[b] = st_q[b];
        end

        if (beat) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
                wr_bank_d = ~wr_bank_q;
            end
            st_d[wr_bank_q] = (wr_cnt_q == 4'd15) ? FULL : FILLING;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // The drained bank is tracked separately since rd_bank has moved on.
        if (hs_last) begin
            st_d[out_bank_q] = EMPTY;
        end

        if (load) begin
            out_valid_d            = 1'b1;
            {out_re_d, out_im_d}   = rd_word;
            out_idx_d              = rd_cnt_q;
            out_last_d             = (rd_cnt_q == 5'd31);
            out_bank_d             = rd_bank_q;
            rd_cnt_d               = rd_cnt_q + 5'd1;
            if (rd_cnt_q == 5'd31) begin
                rd_bank_d = ~rd_bank_q;
            end
            if (st_q[rd_bank_q] == FULL) begin
                st_d[rd_bank_q] = DRAINING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b] <= EMPTY;
            end
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= 4'd0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= 5'd0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= 5'd0;
            out_last_q  <= 1'b0;
            out_bank_q  <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                st_q[b] <= st_d[b];
            end
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_bank_q  <= out_bank_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Testbench for fft_output_reorder: random frames fed in MDC order,
// output compared against the natural-order frame contents.
module tb_fft_output_reorder;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_up_re = '0;
    logic [W-1:0] in_up_im = '0;
    logic [W-1:0] in_l_re = '0;
    logic [W-1:0] in_l_im = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic [4:0]   out_idx;
    logic         out_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fft_output_reorder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_up_re  (in_up_re),
        .in_up_im  (in_up_im),
        .in_l_re   (in_l_re),
        .in_l_im   (in_l_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int rev4(input int k);
        return ((k % 2) * 8) + (((k / 2) % 2) * 4) + (((k / 4) % 2) * 2) + ((k / 8) % 2);
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rand_frames(input int nf, output logic [17:0] fr[$]);
        fr = {};
        for (int i = 0; i < nf * 32; i++) fr.push_back(18'($urandom));
    endtask

    // Feeds beats in MDC order: beat k carries bins rev4(k) and 16+rev4(k).
    task automatic drive(input logic [17:0] fr[$], input int nbeats,
                         input int gap_max, output int acc[$]);
        acc = {};
        for (int b = 0; b < nbeats; b++) begin
            int f;
            int k;
            int g;
            int guard;
            bit ok;
            f = b / 16;
            k = b % 16;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            {in_up_re, in_up_im} = fr[f * 32 + rev4(k)];
            {in_l_re, in_l_im} = fr[f * 32 + 16 + rev4(k)];
            ok = 1'b0;
            guard = 0;
            while (!ok && guard < 500) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    acc.push_back(cyc);
                end
                @(posedge clk);
                #1;
                guard++;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout beat %0d got no in_ready exp accept", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // mode 0: always ready; mode 1: alternate ready, plus 5 low cycles at bin 10.
    task automatic collect(input int n, input int mode, output logic [23:0] got[$],
                           output int hc[$], output int stall_bad);
        int lowcnt;
        bit did_low;
        bit held;
        logic [23:0] hv;
        logic [23:0] cur;
        int guard;
        got = {};
        hc = {};
        stall_bad = 0;
        lowcnt = 0;
        did_low = 1'b0;
        held = 1'b0;
        hv = '0;
        guard = 0;
        while (got.size() < n && guard < 3000) begin
            if (mode == 0) begin
                out_ready = 1'b1;
            end else begin
                if (got.size() == 10 && !did_low) begin
                    did_low = 1'b1;
                    lowcnt = 5;
                end
                if (lowcnt > 0) begin
                    out_ready = 1'b0;
                    lowcnt--;
                end else begin
                    out_ready = ((guard % 2) == 1);
                end
            end
            @(negedge clk);
            cur = {out_re, out_im, out_idx, out_last};
            if (held && (!out_valid || cur !== hv)) stall_bad++;
            held = 1'b0;
            if (out_valid && out_ready) begin
                got.push_back(cur);
                hc.push_back(cyc);
            end else if (out_valid) begin
                held = 1'b1;
                hv = cur;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b1;
        if (got.size() < n) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout got %0d samples exp %0d", got.size(), n);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_re !== 9'd0) begin
            errors++; $display("FAIL reset_out_re got %h exp 0", out_re);
        end
        checks++;
        if (out_im !== 9'd0) begin
            errors++; $display("FAIL reset_out_im got %h exp 0", out_im);
        end
        checks++;
        if (out_idx !== 5'd0) begin
            errors++; $display("FAIL reset_out_idx got %0d exp 0", out_idx);
        end
        checks++;
        if (out_last !== 1'b0) begin
            errors++; $display("FAIL reset_out_last got %b exp 0", out_last);
        end
    endtask

    task automatic test_single_frame();
        logic [17:0] fr[$];
        logic [23:0] got[$];
        logic [23:0] e;
        int acc[$];
        int hc[$];
        int sb;
        apply_reset();
        fr = {};
        for (int n = 0; n < 32; n++) fr.push_back({9'(n), 9'(-n)});
        drive(fr, 16, 0, acc);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_early_valid got %b exp 0", out_valid);
        end
        collect(32, 0, got, hc, sb);
        checks++;
        if (hc.size() < 32 || acc.size() < 16 || hc[0] - acc[15] != 2) begin
            errors++; $display("FAIL single_latency got %0d exp 2",
                               (hc.size() > 0 && acc.size() > 15) ? hc[0] - acc[15] : -1);
        end
        checks++;
        if (hc.size() < 32 || hc[31] - hc[0] != 31) begin
            errors++; $display("FAIL single_contiguous got span %0d exp 31",
                               (hc.size() > 31) ? hc[31] - hc[0] : -1);
        end
        for (int n = 0; n < 32; n++) begin
            e = {fr[n], 5'(n), n == 31};
            checks++;
            if (got[n] !== e) begin
                errors++; $display("FAIL single_bin%0d got %h exp %h", n, got[n], e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] fr[$];
        logic [23:0] got[$];
        logic [23:0] e;
        int acc[$];
        int hc[$];
        int sb;
        apply_reset();
        rand_frames(1, fr);
        fork
            drive(fr, 16, 0, acc);
            collect(32, 1, got, hc, sb);
        join
        checks++;
        if (sb != 0) begin
            errors++; $display("FAIL bp_stall_stable got %0d changes exp 0", sb);
        end
        for (int n = 0; n < 32; n++) begin
            e = {fr[n], 5'(n), n == 31};
            checks++;
            if (got[n] !== e) begin
                errors++; $display("FAIL bp_bin%0d got %h exp %h", n, got[n], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] fr[$];
        logic [23:0] got[$];
        logic [23:0] e;
        int acc[$];
        int hc[$];
        int sb;
        apply_reset();
        rand_frames(3, fr);
        fork
            drive(fr, 48, 0, acc);
            collect(96, 0, got, hc, sb);
        join
        checks++;
        if (acc.size() < 48 || acc[31] - acc[0] != 31) begin
            errors++; $display("FAIL b2b_two_frames got %0d exp 31",
                               (acc.size() > 31) ? acc[31] - acc[0] : -1);
        end
        checks++;
        if (acc.size() < 48 || hc.size() < 96 || acc[32] - hc[31] != 1) begin
            errors++; $display("FAIL b2b_ready_rise got %0d exp 1",
                               (acc.size() > 32 && hc.size() > 31) ? acc[32] - hc[31] : -1);
        end
        checks++;
        if (hc.size() < 96 || hc[95] - hc[0] != 95) begin
            errors++; $display("FAIL b2b_contiguous got %0d exp 95",
                               (hc.size() > 95) ? hc[95] - hc[0] : -1);
        end
        for (int i = 0; i < 96; i++) begin
            e = {fr[i], 5'(i % 32), (i % 32) == 31};
            checks++;
            if (got[i] !== e) begin
                errors++; $display("FAIL b2b_sample%0d got %h exp %h", i, got[i], e);
            end
        end
    endtask

    task automatic test_gaps();
        logic [17:0] fr[$];
        logic [23:0] got[$];
        logic [23:0] e;
        int acc[$];
        int hc[$];
        int sb;
        apply_reset();
        rand_frames(2, fr);
        fork
            drive(fr, 32, 4, acc);
            collect(64, 0, got, hc, sb);
        join
        for (int i = 0; i < 64; i++) begin
            e = {fr[i], 5'(i % 32), (i % 32) == 31};
            checks++;
            if (got[i] !== e) begin
                errors++; $display("FAIL gaps_sample%0d got %h exp %h", i, got[i], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] fa[$];
        logic [17:0] fb[$];
        logic [17:0] fc[$];
        logic [23:0] got[$];
        logic [23:0] e;
        int acc[$];
        int hc[$];
        int sb;
        apply_reset();
        out_ready = 1'b0;
        rand_frames(1, fa);
        rand_frames(1, fb);
        rand_frames(1, fc);
        drive(fa, 16, 0, acc);
        drive(fb, 8, 0, acc);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre_valid got %b exp 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_idx !== 5'd0) begin
            errors++; $display("FAIL rstmid_out_idx got %0d exp 0", out_idx);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        fork
            drive(fc, 16, 0, acc);
            collect(32, 0, got, hc, sb);
        join
        for (int n = 0; n < 32; n++) begin
            e = {fc[n], 5'(n), n == 31};
            checks++;
            if (got[n] !== e) begin
                errors++; $display("FAIL rstmid_bin%0d got %h exp %h", n, got[n], e);
            end
        end
    endtask

    task automatic test_extreme();
        logic [17:0] fr[$];
        logic [23:0] got[$];
        logic [23:0] e;
        logic [8:0] lo;
        logic [8:0] hi;
        int acc[$];
        int hc[$];
        int sb;
        lo = 9'h100;
        hi = 9'h0FF;
        apply_reset();
        fr = {};
        for (int n = 0; n < 32; n++) begin
            fr.push_back({($urandom_range(1, 0) == 1) ? lo : hi,
                          ($urandom_range(1, 0) == 1) ? lo : hi});
        end
        fr[0] = {lo, hi};
        fr[31] = {hi, lo};
        fork
            drive(fr, 16, 2, acc);
            collect(32, 0, got, hc, sb);
        join
        for (int n = 0; n < 32; n++) begin
            e = {fr[n], 5'(n), n == 31};
            checks++;
            if (got[n] !== e) begin
                errors++; $display("FAIL extreme_bin%0d got %h exp %h", n, got[n], e);
            end
        end
        checks++;
        if ($signed(got[0][23:15]) != -256) begin
            errors++; $display("FAIL extreme_sign got %0d exp -256", $signed(got[0][23:15]));
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_extreme();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
